// File: rtl/aes_round_sched_pkg.sv
// rtl/aes_round_sched_pkg.sv - key-size, scheduler-state types and round-count lookup for the AES round scheduler
package aes_round_sched_pkg;

    typedef enum logic [1:0] {
        AES_KEY_128  = 2'd0,
        AES_KEY_192  = 2'd1,
        AES_KEY_256  = 2'd2,
        AES_KEY_RSVD = 2'd3
    } aes_key_size_t;

    typedef enum logic [2:0] {
        SCH_IDLE  = 3'd0,
        SCH_ARMED = 3'd1,
        SCH_LOAD  = 3'd2,
        SCH_ROUND = 3'd3,
        SCH_FINAL = 3'd4,
        SCH_HOLD  = 3'd5,
        SCH_DONE  = 3'd6,
        SCH_ERROR = 3'd7
    } aes_sched_state_t;

    localparam int unsigned AES_NR_128 = 10;
    localparam int unsigned AES_NR_192 = 12;
    localparam int unsigned AES_NR_256 = 14;

    // Reserved key size yields 0; the scheduler never runs rounds for it.
    function automatic logic [3:0] aes_nr(input aes_key_size_t key_size);
        case (key_size)
            AES_KEY_128: aes_nr = 4'(AES_NR_128);
            AES_KEY_192: aes_nr = 4'(AES_NR_192);
            AES_KEY_256: aes_nr = 4'(AES_NR_256);
            default:     aes_nr = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_sched_if.sv
// rtl/aes_round_sched_if.sv - engine-side control, block/result handshakes and datapath strobes of the round scheduler
interface aes_round_sched_if #(
    parameter int BLK_CNT_W = 16,
    parameter int RIDX_W    = 4
);
    logic                 clear;
    logic                 start_i;
    logic [1:0]           key_size_i;
    logic [BLK_CNT_W-1:0] n_blocks_i;
    logic                 blk_valid_i;
    logic                 blk_ready_o;
    logic                 load_o;
    logic                 round_en_o;
    logic [RIDX_W-1:0]    round_idx_o;
    logic                 final_round_o;
    logic                 key_step_o;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic [BLK_CNT_W-1:0] blk_cnt_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;

    modport master (
        output clear, start_i, key_size_i, n_blocks_i, blk_valid_i, res_ready_i,
        input  blk_ready_o, load_o, round_en_o, round_idx_o, final_round_o,
               key_step_o, res_valid_o, blk_cnt_o, busy_o, done_o, err_o
    );

    modport slave (
        input  clear, start_i, key_size_i, n_blocks_i, blk_valid_i, res_ready_i,
        output blk_ready_o, load_o, round_en_o, round_idx_o, final_round_o,
               key_step_o, res_valid_o, blk_cnt_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/aes_round_sched.sv
// rtl/aes_round_sched.sv - per-block round sequencer and per-job block counter for the iterative AES datapath
module aes_round_sched
    import aes_round_sched_pkg::*;
#(
    parameter int BLK_CNT_W = 16,
    parameter int RIDX_W    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    aes_round_sched_if.slave bus
);

    localparam logic [2:0] ST_IDLE  = SCH_IDLE;
    localparam logic [2:0] ST_ARMED = SCH_ARMED;
    localparam logic [2:0] ST_LOAD  = SCH_LOAD;
    localparam logic [2:0] ST_ROUND = SCH_ROUND;
    localparam logic [2:0] ST_FINAL = SCH_FINAL;
    localparam logic [2:0] ST_HOLD  = SCH_HOLD;
    localparam logic [2:0] ST_DONE  = SCH_DONE;
    localparam logic [2:0] ST_ERROR = SCH_ERROR;

    logic [2:0]           state;
    logic [RIDX_W-1:0]    nr;
    logic [RIDX_W-1:0]    rnd;
    logic [BLK_CNT_W-1:0] n_blk;
    logic [BLK_CNT_W-1:0] blk_cnt;
    logic                 err;

    logic blk_hs;
    logic res_hs;
    logic last_blk;
    logic last_mid_round;
    logic in_rounds;

    assign blk_hs         = (state == ST_ARMED) && bus.blk_valid_i;
    assign res_hs         = (state == ST_HOLD) && bus.res_ready_i;
    assign last_blk       = (blk_cnt == (n_blk - BLK_CNT_W'(1)));
    assign last_mid_round = (rnd == (nr - RIDX_W'(1)));
    assign in_rounds      = (state == ST_LOAD) || (state == ST_ROUND) || (state == ST_FINAL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            nr      <= '0;
            rnd     <= '0;
            n_blk   <= '0;
            blk_cnt <= '0;
            err     <= 1'b0;
        end else if (bus.clear) begin
            state   <= ST_IDLE;
            nr      <= '0;
            rnd     <= '0;
            n_blk   <= '0;
            blk_cnt <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        blk_cnt <= '0;
                        n_blk   <= bus.n_blocks_i;
                        nr      <= RIDX_W'(aes_nr(aes_key_size_t'(bus.key_size_i)));
                        if (bus.key_size_i == AES_KEY_RSVD) begin
                            err   <= 1'b1;
                            state <= ST_ERROR;
                        end else if (bus.n_blocks_i == '0) begin
                            err   <= 1'b0;
                            state <= ST_DONE;
                        end else begin
                            err   <= 1'b0;
                            state <= ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (blk_hs) begin
                        rnd   <= '0;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    rnd   <= RIDX_W'(1);
                    state <= ST_ROUND;
                end
                // The round index keeps counting into FINAL so it reads Nr there.
                ST_ROUND: begin
                    rnd <= rnd + RIDX_W'(1);
                    if (last_mid_round) begin
                        state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    rnd   <= '0;
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_hs) begin
                        if (blk_cnt != '1) begin
                            blk_cnt <= blk_cnt + BLK_CNT_W'(1);
                        end
                        state <= last_blk ? ST_DONE : ST_ARMED;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                ST_ERROR: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // All strobes decode straight from the state so an async reset clears them at once.
    assign bus.blk_ready_o   = (state == ST_ARMED);
    assign bus.load_o        = (state == ST_LOAD);
    assign bus.round_en_o    = (state == ST_ROUND) || (state == ST_FINAL);
    assign bus.final_round_o = (state == ST_FINAL);
    assign bus.key_step_o    = (state == ST_LOAD) || (state == ST_ROUND);
    assign bus.round_idx_o   = in_rounds ? rnd : '0;
    assign bus.res_valid_o   = (state == ST_HOLD);
    assign bus.blk_cnt_o     = blk_cnt;
    assign bus.busy_o        = (state == ST_ARMED) || in_rounds || (state == ST_HOLD);
    assign bus.done_o        = (state == ST_DONE) || (state == ST_ERROR);
    assign bus.err_o         = err;

endmodule

// File: tb/tb_aes_round_sched.sv
// tb/tb_aes_round_sched.sv - scoreboard bench for aes_round_sched driven by directed job vectors
module tb_aes_round_sched;

    localparam int EV_LOAD = 1;
    localparam int EV_RND  = 2;
    localparam int EV_FIN  = 3;
    localparam int EV_RES  = 4;
    localparam int EV_DONE = 5;

    typedef struct {
        int kind;
        int cyc;
        int val;
        int ks;
        int err;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   busy_cnt = 0;
    int   ks_cnt = 0;
    int   ks_rnd_cnt = 0;
    ev_t  exp_q[$];

    aes_round_sched_if #(.BLK_CNT_W(16), .RIDX_W(4)) bus ();

    aes_round_sched #(.BLK_CNT_W(16), .RIDX_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int kind, input int c, input int val, input int ks, input int err);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        e.ks   = ks;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        logic [28:0] v;
        v = {bus.blk_ready_o, bus.load_o, bus.round_en_o, bus.round_idx_o, bus.final_round_o,
             bus.key_step_o, bus.res_valid_o, bus.blk_cnt_o, bus.busy_o, bus.done_o, bus.err_o};
        chk(name, int'(v), 0);
    endtask

    task automatic do_start(input int key, input int n);
        bus.start_i    = 1'b1;
        bus.key_size_i = 2'(key);
        bus.n_blocks_i = 16'(n);
        step();
        bus.start_i    = 1'b0;
    endtask

    // Call in an ARMED cycle; returns in the cycle after the result handshake.
    task automatic run_block(input int nr, input int hold, input int cnt0, input bit last, input bit early);
        int t;
        int ready_at;
        t = cyc;
        push(EV_LOAD, t + 1, 0, 1, 0);
        for (int i = 1; i < nr; i++) push(EV_RND, t + 1 + i, i, 1, 0);
        push(EV_FIN, t + nr + 1, nr, 0, 0);
        for (int j = 0; j <= hold; j++) push(EV_RES, t + nr + 2 + j, cnt0, 0, 0);
        if (last) push(EV_DONE, t + nr + 3 + hold, cnt0 + 1, 0, 0);
        bus.blk_valid_i = 1'b1;
        step();
        bus.blk_valid_i = 1'b0;
        ready_at = early ? t + nr : t + nr + 2 + hold;
        while (cyc < ready_at) step();
        bus.res_ready_i = 1'b1;
        while (cyc < t + nr + 2 + hold) step();
        step();
        bus.res_ready_i = 1'b0;
    endtask

    always @(negedge clk) begin
        int  kind;
        int  val;
        ev_t e;
        if (bus.busy_o) busy_cnt++;
        if (bus.key_step_o) ks_cnt++;
        if (bus.key_step_o && bus.round_en_o) ks_rnd_cnt++;
        if (bus.load_o || bus.round_en_o || bus.res_valid_o || bus.done_o) begin
            if (bus.load_o) kind = EV_LOAD;
            else if (bus.final_round_o) kind = EV_FIN;
            else if (bus.round_en_o) kind = EV_RND;
            else if (bus.res_valid_o) kind = EV_RES;
            else kind = EV_DONE;
            val = (kind == EV_RES || kind == EV_DONE) ? int'(bus.blk_cnt_o) : int'(bus.round_idx_o);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("ev_kind@%0d", e.cyc), kind, e.kind);
                chk($sformatf("ev_cycle(kind %0d)", e.kind), cyc, e.cyc);
                chk($sformatf("ev_value@%0d", e.cyc), val, e.val);
                chk($sformatf("ev_key_step@%0d", e.cyc), int'(bus.key_step_o), e.ks);
                chk($sformatf("ev_err@%0d", e.cyc), int'(bus.err_o), e.err);
                chk($sformatf("ev_busy@%0d", e.cyc), int'(bus.busy_o), (e.kind == EV_DONE) ? 0 : 1);
            end
        end
        if (bus.blk_ready_o)
            chk("ready_exclusive", int'({bus.load_o, bus.round_en_o, bus.res_valid_o, bus.done_o, !bus.busy_o}), 0);
        if (!(bus.load_o || bus.round_en_o))
            chk("round_idx_outside_rounds", int'(bus.round_idx_o), 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int k0;
        int kr0;
        int b0;
        bus.clear       = 1'b0;
        bus.start_i     = 1'b0;
        bus.key_size_i  = 2'd0;
        bus.n_blocks_i  = 16'd0;
        bus.blk_valid_i = 1'b0;
        bus.res_ready_i = 1'b0;
        step();
        step();
        check_zero("reset_state");
        reset_n = 1'b1;
        step();
        check_zero("idle_after_reset");

        // AES-128, one block, result taken as soon as it appears
        do_start(0, 1);
        step();
        run_block(10, 0, 0, 1'b1, 1'b1);
        step();
        chk("blk_cnt_holds_after_done", int'(bus.blk_cnt_o), 1);

        // AES-256, three blocks, serializer stalls 5 cycles per result
        k0  = ks_cnt;
        kr0 = ks_rnd_cnt;
        do_start(2, 3);
        run_block(14, 5, 0, 1'b0, 1'b0);
        run_block(14, 5, 1, 1'b0, 1'b0);
        run_block(14, 5, 2, 1'b1, 1'b0);
        step();
        chk("key_steps_total_aes256", ks_cnt - k0, 42);
        chk("key_steps_in_rounds_aes256", ks_rnd_cnt - kr0, 39);
        chk("blk_cnt_aes256", int'(bus.blk_cnt_o), 3);

        // reserved key size
        push(EV_DONE, cyc + 1, 0, 0, 1);
        do_start(3, 5);
        step();
        step();
        chk("err_sticky", int'(bus.err_o), 1);

        // zero-block job, also clears the error
        b0 = busy_cnt;
        push(EV_DONE, cyc + 1, 0, 0, 0);
        do_start(0, 0);
        step();
        step();
        chk("zero_job_never_busy", busy_cnt - b0, 0);
        chk("err_cleared_by_start", int'(bus.err_o), 0);

        // clear during round 5 of AES-192
        do_start(1, 2);
        t = cyc;
        push(EV_LOAD, t + 1, 0, 1, 0);
        for (int i = 1; i <= 5; i++) push(EV_RND, t + 1 + i, i, 1, 0);
        bus.blk_valid_i = 1'b1;
        step();
        bus.blk_valid_i = 1'b0;
        while (cyc < t + 6) step();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        check_zero("outputs_after_clear");
        step();
        do_start(1, 1);
        run_block(12, 1, 0, 1'b1, 1'b0);
        step();

        // stray start/valid ignored; async reset drops the held result
        do_start(0, 2);
        t = cyc;
        push(EV_LOAD, t + 1, 0, 1, 0);
        for (int i = 1; i < 10; i++) push(EV_RND, t + 1 + i, i, 1, 0);
        push(EV_FIN, t + 11, 10, 0, 0);
        push(EV_RES, t + 12, 0, 0, 0);
        push(EV_RES, t + 13, 0, 0, 0);
        bus.blk_valid_i = 1'b1;
        while (cyc < t + 5) step();
        bus.start_i    = 1'b1;
        bus.key_size_i = 2'd3;
        bus.n_blocks_i = 16'd0;
        step();
        bus.start_i = 1'b0;
        while (cyc < t + 14) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("res_valid_async_drop", int'(bus.res_valid_o), 0);
        check_zero("outputs_async_reset");
        step();
        bus.blk_valid_i = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        step();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
